// File: rtl/bp_clint_timer.sv
// bp_clint_timer
//   Single-core CLINT device. It holds the machine software-interrupt (mipi),
//   timer-compare (mtimecmp) and free-running timer (mtime) registers. It
//   services one 64b load/store at a time and drives the core's software and
//   timer interrupt lines.
//
// Ports
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   req_v_i        request valid; accepted when req_v_i & req_ready_o
//   req_ready_o    high while idle (READY state)
//   req_w_i        1 = store, 0 = load
//   req_addr_i     physical address; only [23:0] decoded
//   req_data_i     store data
//   resp_v_o       response valid, held until resp_yumi_i
//   resp_yumi_i    consumer takes the response
//   resp_data_o    load data; 0 for stores and errors
//   resp_err_o     access to an unmapped offset
//   software_irq_o mipi[0]
//   timer_irq_o    mtime >= mtimecmp (unsigned)
module bp_clint_timer #(
   parameter int paddr_width_p = 40,
   parameter int dword_width_p = 64,
   parameter int mtime_div_p   = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     req_v_i,
   output logic                     req_ready_o,
   input  logic                     req_w_i,
   input  logic [paddr_width_p-1:0] req_addr_i,
   input  logic [dword_width_p-1:0] req_data_i,
   output logic                     resp_v_o,
   input  logic                     resp_yumi_i,
   output logic [dword_width_p-1:0] resp_data_o,
   output logic                     resp_err_o,
   output logic                     software_irq_o,
   output logic                     timer_irq_o
);

   typedef enum logic {S_READY, S_RESP} state_e;

   localparam int            PW     = (mtime_div_p > 1) ? $clog2(mtime_div_p) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(mtime_div_p - 1);

   localparam logic [23:0] OFF_MIPI     = 24'h30_0000;
   localparam logic [23:0] OFF_MTIMECMP = 24'h30_4000;
   localparam logic [23:0] OFF_MTIME    = 24'h30_bff8;

   state_e                   state;
   logic [PW-1:0]            ps;
   logic                     tick;
   logic [dword_width_p-1:0] mtime, mtimecmp;
   logic                     mipi;

   logic [23:0]              off;
   logic                     sel_mipi, sel_cmp, sel_time, unmapped;
   logic                     accept, wr;
   logic [dword_width_p-1:0] rdata;

   // The router has already selected this device, so the upper address bits
   // carry no information here.
   logic unused_addr;
   assign unused_addr = ^req_addr_i[paddr_width_p-1:24];

   assign off      = req_addr_i[23:0];
   assign sel_mipi = (off == OFF_MIPI);
   assign sel_cmp  = (off == OFF_MTIMECMP);
   assign sel_time = (off == OFF_MTIME);
   assign unmapped = ~(sel_mipi | sel_cmp | sel_time);

   assign accept = req_v_i & (state == S_READY);
   assign wr     = accept & req_w_i;
   assign tick   = (ps == PS_MAX);

   always_comb begin
      rdata = '0;
      if (sel_mipi)      rdata = dword_width_p'(mipi);
      else if (sel_cmp)  rdata = mtimecmp;
      else if (sel_time) rdata = mtime;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= S_READY;
         ps          <= '0;
         mtime       <= '0;
         mtimecmp    <= '1;
         mipi        <= 1'b0;
         resp_data_o <= '0;
         resp_err_o  <= 1'b0;
      end else begin
         ps <= tick ? '0 : ps + PW'(1);

         // A store to mtime overrides the increment in the same cycle; the
         // prescaler keeps running so the next tick stays on its schedule.
         if (wr && sel_time) mtime <= req_data_i;
         else if (tick)      mtime <= mtime + 1'b1;

         if (wr && sel_cmp)  mtimecmp <= req_data_i;
         if (wr && sel_mipi) mipi     <= req_data_i[0];

         case (state)
            S_READY: if (req_v_i) begin
               // Loads see register values from before this edge's update.
               resp_data_o <= (req_w_i || unmapped) ? '0 : rdata;
               resp_err_o  <= unmapped;
               state       <= S_RESP;
            end
            S_RESP: if (resp_yumi_i) state <= S_READY;
            default: state <= S_READY;
         endcase
      end
   end

   assign req_ready_o    = (state == S_READY);
   assign resp_v_o       = (state == S_RESP);
   assign software_irq_o = mipi;
   assign timer_irq_o    = (mtime >= mtimecmp);

endmodule

// File: tb/tb_bp_clint_timer.sv
// Bench for bp_clint_timer: directed stimulus pushes the expected {err,data}
// of each request into a queue; a monitor pops and compares whenever the
// DUT presents a response. Cycle index cyc counts non-reset clock edges so
// expected mtime values can be derived by hand (mtime_div_p = 8).
module tb_bp_clint_timer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        req_v_i;
   logic        req_ready_o;
   logic        req_w_i;
   logic [39:0] req_addr_i;
   logic [63:0] req_data_i;
   logic        resp_v_o;
   logic        resp_yumi_i = 1'b0;
   logic [63:0] resp_data_o;
   logic        resp_err_o;
   logic        software_irq_o;
   logic        timer_irq_o;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic        hold_yumi = 1'b0;
   logic [64:0] exp_q[$];

   localparam logic [39:0] A_MIPI = 40'h00_0030_0000;
   localparam logic [39:0] A_CMP  = 40'h00_0030_4000;
   localparam logic [39:0] A_TIME = 40'h00_0030_bff8;
   localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

   bp_clint_timer #(.paddr_width_p(40), .dword_width_p(64), .mtime_div_p(8)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_w_i(req_w_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
      .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
      .software_irq_o(software_irq_o), .timer_irq_o(timer_irq_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_i) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: compare and consume each response unless the bench is holding it.
   always @(negedge clk) begin
      if (resp_v_o && !hold_yumi) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", {resp_err_o, resp_data_o}, 65'h0);
         end else begin
            chk("resp", {resp_err_o, resp_data_o}, exp_q.pop_front());
         end
         resp_yumi_i = 1'b1;
      end else begin
         resp_yumi_i = 1'b0;
      end
   end

   // Called just after a posedge with the DUT idle; the accept cycle is cyc.
   // Returns just after the posedge that consumed the response.
   task automatic do_req(input logic w, input logic [39:0] a, input logic [63:0] d,
                         input logic [63:0] ed, input logic ee);
      int n;
      logic acc;
      exp_q.push_back({ee, ed});
      req_w_i = w; req_addr_i = a; req_data_i = d; req_v_i = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 20) begin
         @(negedge clk); acc = req_ready_o;
         @(posedge clk); #1; n++;
      end
      req_v_i = 1'b0;
      if (!acc) chk("accept_timeout", 65'(n), 65'h0);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (exp_q.size() != 0) begin
         chk("resp_timeout", 65'(exp_q.size()), 65'h0);
         exp_q.delete();
      end
   endtask

   task automatic wait_cyc_mod7;
      while (cyc % 8 != 7) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int n;
      reset_i = 1'b1; req_v_i = 1'b0; req_w_i = 1'b0;
      req_addr_i = '0; req_data_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_v",  65'(resp_v_o), 65'h0);
      chk("rst_ready",   65'(req_ready_o), 65'h1);
      chk("rst_resp",    {resp_err_o, resp_data_o}, 65'h0);
      chk("rst_irqs",    65'({software_irq_o, timer_irq_o}), 65'h0);
      reset_i = 1'b0;

      // 1: 80 cycles at div 8 -> mtime 10
      repeat (80) @(posedge clk);
      #1;
      chk("t1_irqs", 65'({software_irq_o, timer_irq_o}), 65'h0);
      do_req(1'b0, A_TIME, 64'h0, 64'd10, 1'b0);            // accept cycle 80

      // 2: mtimecmp = 20; mtime reaches 20 at the edge closing cycle 159
      do_req(1'b1, A_CMP, 64'd20, 64'h0, 1'b0);             // cycle 82
      chk("t2_irq_pre", 65'(timer_irq_o), 65'h0);
      n = 0;
      do begin @(negedge clk); n++; end while (!timer_irq_o && n < 200);
      chk("t2_irq_rise_cyc", 65'(cyc), 65'd160);
      @(posedge clk); #1;
      chk("t2_irq_high", 65'(timer_irq_o), 65'h1);
      do_req(1'b1, A_CMP, ONES, 64'h0, 1'b0);
      chk("t2_irq_clear", 65'(timer_irq_o), 65'h0);

      // 3: mipi only keeps bit 0
      do_req(1'b1, A_MIPI, ONES, 64'h0, 1'b0);
      chk("t3_sw_set", 65'(software_irq_o), 65'h1);
      do_req(1'b0, A_MIPI, 64'h0, 64'h1, 1'b0);
      do_req(1'b1, A_MIPI, 64'h0, 64'h0, 1'b0);
      chk("t3_sw_clr", 65'(software_irq_o), 65'h0);

      // 4: mtime wrap, and store in a tick cycle beats the tick
      wait_cyc_mod7();
      c = cyc;
      do_req(1'b1, A_TIME, ONES, 64'h0, 1'b0);
      while (cyc != c + 9) begin @(posedge clk); #1; end
      do_req(1'b0, A_TIME, 64'h0, 64'h0, 1'b0);
      wait_cyc_mod7();
      c = cyc;
      do_req(1'b1, A_TIME, 64'h55, 64'h0, 1'b0);
      do_req(1'b0, A_TIME, 64'h0, 64'h55, 1'b0);           // no tick since store
      while (cyc != c + 10) begin @(posedge clk); #1; end
      do_req(1'b0, A_TIME, 64'h0, 64'h56, 1'b0);           // one tick at c+8

      // 5: unmapped load, response held for 5 cycles
      hold_yumi = 1'b1;
      exp_q.push_back({1'b1, 64'h0});
      req_w_i = 1'b0; req_addr_i = 40'h00_0030_0008; req_v_i = 1'b1;
      @(posedge clk); #1;
      req_v_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_v",     65'(resp_v_o), 65'h1);
         chk("t5_hold_ready", 65'(req_ready_o), 65'h0);
         chk("t5_hold_resp",  {resp_err_o, resp_data_o}, {1'b1, 64'h0});
      end
      @(posedge clk); #1;
      hold_yumi = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
      chk("t5_drain", 65'(exp_q.size()), 65'h0);
      do_req(1'b1, 40'h00_0030_4008, 64'h1234, 64'h0, 1'b1);  // unmapped store
      do_req(1'b0, A_CMP, 64'h0, ONES, 1'b0);
      do_req(1'b0, A_MIPI, 64'h0, 64'h0, 1'b0);
      do_req(1'b0, 40'hAB_0030_4000, 64'h0, ONES, 1'b0);      // upper bits ignored

      // 6: reset while a response is pending
      do_req(1'b1, A_MIPI, 64'h1, 64'h0, 1'b0);
      do_req(1'b1, A_CMP, 64'h0, 64'h0, 1'b0);
      chk("t6_irqs_pre", 65'({software_irq_o, timer_irq_o}), 65'h3);
      hold_yumi = 1'b1;
      req_w_i = 1'b0; req_addr_i = A_CMP; req_v_i = 1'b1;
      @(posedge clk); #1;
      req_v_i = 1'b0;
      @(negedge clk);
      chk("t6_resp_pending", 65'(resp_v_o), 65'h1);
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      chk("t6_resp_v",  65'(resp_v_o), 65'h0);
      chk("t6_ready",   65'(req_ready_o), 65'h1);
      chk("t6_resp",    {resp_err_o, resp_data_o}, 65'h0);
      chk("t6_irqs",    65'({software_irq_o, timer_irq_o}), 65'h0);
      hold_yumi = 1'b0;
      do_req(1'b0, A_TIME, 64'h0, 64'h0, 1'b0);             // accept cycle 0
      do_req(1'b0, A_CMP, 64'h0, ONES, 1'b0);
      do_req(1'b0, A_MIPI, 64'h0, 64'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
